// File: rtl/debug_cmd_engine_if.sv
// Byte-stream and debug register-bus signals for debug_cmd_engine.
// The master modport is the engine side; slave is the byte source/sink plus register file.
interface debug_cmd_engine_if;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic [7:0]  dbg_a;
  logic [15:0] dbg_di;
  logic        dbg_we;
  logic        dbg_rd;
  logic [15:0] dbg_do;
  logic        dbg_ready;

  modport master (
    input  rx_data, rx_valid, tx_ready, dbg_do, dbg_ready,
    output rx_ready, tx_data, tx_valid, dbg_a, dbg_di, dbg_we, dbg_rd
  );

  modport slave (
    output rx_data, rx_valid, tx_ready, dbg_do, dbg_ready,
    input  rx_ready, tx_data, tx_valid, dbg_a, dbg_di, dbg_we, dbg_rd
  );
endinterface

// File: rtl/debug_cmd_engine.sv
// Byte-frame command engine driving the debug register bus with access and inter-byte timeouts.
// Define DEBUG_BURST_READ_EN to compile in the 0x62 burst-read opcode and its CNT state.
module debug_cmd_engine #(
  parameter int unsigned TIMEOUT_BITS = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  debug_cmd_engine_if.master bus,
  output logic               busy
);
  typedef enum logic [3:0] {
    S_IDLE, S_ADDR, S_DLO, S_DHI,
`ifdef DEBUG_BURST_READ_EN
    S_CNT,
`endif
    S_ACCESS, S_TX_LO, S_TX_HI, S_TX_ACK, S_TX_NAK
  } state_e;

  localparam logic [7:0] OP_WR = 8'h77;
  localparam logic [7:0] OP_RD = 8'h72;
`ifdef DEBUG_BURST_READ_EN
  localparam logic [7:0] OP_BURST = 8'h62;
`endif
  localparam logic [7:0] ACK = 8'h06;
  localparam logic [7:0] NAK = 8'h15;
  // Counter value seen during the (2^N-1)-th waiting cycle.
  localparam logic [TIMEOUT_BITS-1:0] TO_LAST = {{(TIMEOUT_BITS-1){1'b1}}, 1'b0};

  state_e                  state_q, state_d;
  logic                    wr_q, wr_d;
  logic [7:0]              a_q, a_d;
  logic [15:0]             di_q, di_d;
  logic [15:0]             hold_q, hold_d;
  logic [7:0]              tx_data_q, tx_data_d;
  logic                    tx_valid_q, tx_valid_d;
  logic                    we_q, we_d;
  logic                    rd_q, rd_d;
  logic [TIMEOUT_BITS-1:0] to_q, to_d;
`ifdef DEBUG_BURST_READ_EN
  logic                    bst_q, bst_d;
  logic [7:0]              cnt_q, cnt_d;
`endif
  logic                    rx_ready_w, rx_fire, to_hit, timed;

  always_comb begin
    case (state_q)
      S_IDLE, S_ADDR, S_DLO, S_DHI: rx_ready_w = 1'b1;
`ifdef DEBUG_BURST_READ_EN
      S_CNT:                        rx_ready_w = 1'b1;
`endif
      default:                      rx_ready_w = 1'b0;
    endcase
  end

  assign rx_fire = bus.rx_valid & rx_ready_w;
  assign to_hit  = (to_q == TO_LAST);
  assign timed   = (state_q == S_ACCESS) || (rx_ready_w && (state_q != S_IDLE));

  always_comb begin
    state_d = state_q;
    wr_d    = wr_q;
    a_d     = a_q;
    di_d    = di_q;
    hold_d  = hold_q;
`ifdef DEBUG_BURST_READ_EN
    bst_d   = bst_q;
    cnt_d   = cnt_q;
`endif
    case (state_q)
      S_IDLE: if (rx_fire) begin
        case (bus.rx_data)
          OP_WR: begin
            wr_d    = 1'b1;
            state_d = S_ADDR;
`ifdef DEBUG_BURST_READ_EN
            bst_d   = 1'b0;
`endif
          end
          OP_RD: begin
            wr_d    = 1'b0;
            state_d = S_ADDR;
`ifdef DEBUG_BURST_READ_EN
            bst_d   = 1'b0;
`endif
          end
`ifdef DEBUG_BURST_READ_EN
          OP_BURST: begin
            wr_d    = 1'b0;
            bst_d   = 1'b1;
            state_d = S_ADDR;
          end
`endif
          default: state_d = S_TX_NAK;
        endcase
      end
      S_ADDR: begin
        if (rx_fire) begin
          a_d = bus.rx_data;
          if (wr_q) begin
            state_d = S_DLO;
          end else begin
`ifdef DEBUG_BURST_READ_EN
            if (bst_q) begin
              state_d = S_CNT;
            end else begin
              cnt_d   = 8'd1;
              state_d = S_ACCESS;
            end
`else
            state_d = S_ACCESS;
`endif
          end
        end else if (to_hit) begin
          state_d = S_IDLE;
        end
      end
      S_DLO: begin
        if (rx_fire) begin
          di_d[7:0] = bus.rx_data;
          state_d   = S_DHI;
        end else if (to_hit) begin
          state_d = S_IDLE;
        end
      end
      S_DHI: begin
        if (rx_fire) begin
          di_d[15:8] = bus.rx_data;
          state_d    = S_ACCESS;
        end else if (to_hit) begin
          state_d = S_IDLE;
        end
      end
`ifdef DEBUG_BURST_READ_EN
      // Count 0 wraps through 255..1 on decrement, giving 256 reads.
      S_CNT: begin
        if (rx_fire) begin
          cnt_d   = bus.rx_data;
          state_d = S_ACCESS;
        end else if (to_hit) begin
          state_d = S_IDLE;
        end
      end
`endif
      S_ACCESS: begin
        if (bus.dbg_ready) begin
          hold_d  = bus.dbg_do;
          state_d = wr_q ? S_TX_ACK : S_TX_LO;
        end else if (to_hit) begin
`ifdef DEBUG_BURST_READ_EN
          cnt_d   = 8'd0;
`endif
          state_d = S_TX_NAK;
        end
      end
      S_TX_LO: if (bus.tx_ready) state_d = S_TX_HI;
      S_TX_HI: if (bus.tx_ready) begin
`ifdef DEBUG_BURST_READ_EN
        cnt_d   = cnt_q - 8'd1;
        state_d = (cnt_d != 8'd0) ? S_ACCESS : S_IDLE;
`else
        state_d = S_IDLE;
`endif
      end
      S_TX_ACK, S_TX_NAK: if (bus.tx_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Registered outputs are decoded from the next state so they align with it.
    we_d       = (state_d == S_ACCESS) && wr_d;
    rd_d       = (state_d == S_ACCESS) && !wr_d;
    tx_valid_d = (state_d == S_TX_LO) || (state_d == S_TX_HI) ||
                 (state_d == S_TX_ACK) || (state_d == S_TX_NAK);
    tx_data_d  = tx_data_q;
    case (state_d)
      S_TX_LO:  tx_data_d = hold_d[7:0];
      S_TX_HI:  tx_data_d = hold_d[15:8];
      S_TX_ACK: tx_data_d = ACK;
      S_TX_NAK: tx_data_d = NAK;
      default:  ;
    endcase

    if ((state_d != state_q) || rx_fire || !timed) to_d = '0;
    else                                           to_d = to_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      wr_q       <= 1'b0;
      a_q        <= '0;
      di_q       <= '0;
      hold_q     <= '0;
      tx_data_q  <= '0;
      tx_valid_q <= 1'b0;
      we_q       <= 1'b0;
      rd_q       <= 1'b0;
      to_q       <= '0;
`ifdef DEBUG_BURST_READ_EN
      bst_q      <= 1'b0;
      cnt_q      <= '0;
`endif
    end else begin
      state_q    <= state_d;
      wr_q       <= wr_d;
      a_q        <= a_d;
      di_q       <= di_d;
      hold_q     <= hold_d;
      tx_data_q  <= tx_data_d;
      tx_valid_q <= tx_valid_d;
      we_q       <= we_d;
      rd_q       <= rd_d;
      to_q       <= to_d;
`ifdef DEBUG_BURST_READ_EN
      bst_q      <= bst_d;
      cnt_q      <= cnt_d;
`endif
    end
  end

  assign bus.rx_ready = rx_ready_w;
  assign bus.tx_data  = tx_data_q;
  assign bus.tx_valid = tx_valid_q;
  assign bus.dbg_a    = a_q;
  assign bus.dbg_di   = di_q;
  assign bus.dbg_we   = we_q;
  assign bus.dbg_rd   = rd_q;
  assign busy         = (state_q != S_IDLE);
endmodule

// File: tb/tb_debug_cmd_engine.sv
// Self-checking bench for debug_cmd_engine: register-file responder, monitor, and a
// register-level reference model of expected response bytes.
module tb_debug_cmd_engine;
  localparam int unsigned TOB = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic busy;
  int   total = 0;
  int   bad = 0;
  int   cyc = 0;

  debug_cmd_engine_if bus();

  debug_cmd_engine #(.TIMEOUT_BITS(TOB)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus),
    .busy (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic logic [15:0] init_val(int i);
    return 16'(i * 257) ^ 16'h5A3C;
  endfunction

  // Register-file responder: ready after ready_after strobe cycles, 0x20 auto-increments on read.
  logic [15:0] resp_mem [256];
  int hold_cnt;
  int ready_after = 1;
  bit ready_en = 1'b1;
  assign bus.dbg_ready = (bus.dbg_we | bus.dbg_rd) && ready_en && (hold_cnt >= ready_after - 1);
  assign bus.dbg_do    = resp_mem[bus.dbg_a];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_cnt <= 0;
      for (int i = 0; i < 256; i++) resp_mem[i] <= init_val(i);
    end else begin
      if (!(bus.dbg_we | bus.dbg_rd) || bus.dbg_ready) hold_cnt <= 0;
      else hold_cnt <= hold_cnt + 1;
      if (bus.dbg_we && bus.dbg_ready) resp_mem[bus.dbg_a] <= bus.dbg_di;
      if (bus.dbg_rd && bus.dbg_ready && bus.dbg_a == 8'h20) resp_mem[8'h20] <= resp_mem[8'h20] + 16'd1;
    end
  end

  // Monitor: accepted TX bytes, strobe pulses (length, kind), capture of bus at strobe rise.
  logic [7:0]  txbuf [1024];
  int          tx_wr = 0;
  int          slen [1024];
  bit          s_we [1024];
  int          s_wr = 0;
  int          cur_len = 0;
  bit          cur_we = 1'b0;
  bit          prev_stb = 1'b0;
  bit          prev_txv = 1'b0;
  int          rise_cyc = -1;
  int          txrise_cyc = -1;
  logic [7:0]  cap_a = '0;
  logic [15:0] cap_di = '0;
  logic        stb;
  assign stb = bus.dbg_we | bus.dbg_rd;

  always @(negedge clk) begin
    if (!rst_n) begin
      prev_stb <= 1'b0;
      prev_txv <= 1'b0;
      cur_len  <= 0;
    end else begin
      if (bus.tx_valid && bus.tx_ready) begin
        txbuf[tx_wr % 1024] <= bus.tx_data;
        tx_wr <= tx_wr + 1;
      end
      if (bus.tx_valid && !prev_txv) txrise_cyc <= cyc;
      if (stb && !prev_stb) begin
        rise_cyc <= cyc;
        cap_a    <= bus.dbg_a;
        cap_di   <= bus.dbg_di;
        cur_we   <= bus.dbg_we;
        cur_len  <= 1;
      end else if (stb) begin
        cur_len <= cur_len + 1;
      end
      if (!stb && prev_stb) begin
        slen[s_wr % 1024] <= cur_len;
        s_we[s_wr % 1024] <= cur_we;
        s_wr <= s_wr + 1;
      end
      prev_stb <= stb;
      prev_txv <= bus.tx_valid;
    end
  end

  logic [15:0] mdl [256];
  localparam logic [36:0] RST_VEC = {1'b1, 1'b0, 8'h00, 8'h00, 16'h0000, 1'b0, 1'b0, 1'b0};

  function automatic logic [36:0] out_vec();
    return {bus.rx_ready, bus.tx_valid, bus.tx_data, bus.dbg_a, bus.dbg_di, bus.dbg_we, bus.dbg_rd, busy};
  endfunction

  task automatic init_model();
    for (int i = 0; i < 256; i++) mdl[i] = init_val(i);
  endtask

  task automatic send_byte(input logic [7:0] b, output int acc);
    int n;
    n = 0;
    @(negedge clk);
    bus.rx_data  = b;
    bus.rx_valid = 1'b1;
    while (!bus.rx_ready && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (!bus.rx_ready) begin
      total++; bad++;
      $display("FAIL send_byte %02h: rx_ready=%0b required 1 within 300 cycles", b, bus.rx_ready);
    end
    @(posedge clk);
    #1;
    acc = cyc;
    bus.rx_valid = 1'b0;
  endtask

  task automatic wait_tx(input int n, output bit ok);
    int k;
    k = 0;
    while (tx_wr < n && k < 600) begin
      @(negedge clk);
      k++;
    end
    ok = (tx_wr >= n);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    total++;
    if (out_vec() !== RST_VEC) begin
      bad++; $display("FAIL reset_hold: outputs=%h required %h", out_vec(), RST_VEC);
    end
    rst_n = 1'b1;
    init_model();
    repeat (2) @(negedge clk);
    total++;
    if (out_vec() !== RST_VEC) begin
      bad++; $display("FAIL reset_release: outputs=%h required %h", out_vec(), RST_VEC);
    end
  endtask

  task automatic test_write();
    int bt, bs, acc;
    bit ok;
    bt = tx_wr; bs = s_wr; ready_after = 1;
    send_byte(8'h77, acc); send_byte(8'h1A, acc); send_byte(8'h34, acc); send_byte(8'h12, acc);
    wait_tx(bt + 1, ok);
    total++;
    if (!ok) begin bad++; $display("FAIL write_resp: tx count=%0d required %0d", tx_wr - bt, 1); end
    total++;
    if (txbuf[bt % 1024] !== 8'h06) begin bad++; $display("FAIL write_ack: got %02h required 06", txbuf[bt % 1024]); end
    total++;
    if (s_wr - bs != 1 || slen[bs % 1024] != 1 || s_we[bs % 1024] != 1'b1) begin
      bad++; $display("FAIL write_strobe: pulses=%0d len=%0d we=%0b required 1/1/1", s_wr - bs, slen[bs % 1024], s_we[bs % 1024]);
    end
    total++;
    if ({cap_a, cap_di} !== {8'h1A, 16'h1234}) begin
      bad++; $display("FAIL write_bus: a/di=%h required 1a1234", {cap_a, cap_di});
    end
    total++;
    if (rise_cyc != acc || txrise_cyc != acc + 1) begin
      bad++; $display("FAIL write_latency: strobe@%0d tx@%0d required %0d/%0d", rise_cyc, txrise_cyc, acc, acc + 1);
    end
    mdl[8'h1A] = 16'h1234;
  endtask

  task automatic test_read();
    int bt, bs, acc;
    bit ok;
    bt = tx_wr; ready_after = 1;
    send_byte(8'h77, acc); send_byte(8'h41, acc); send_byte(8'hEF, acc); send_byte(8'hBE, acc);
    wait_tx(bt + 1, ok);
    mdl[8'h41] = 16'hBEEF;
    total++;
    if (!ok || txbuf[bt % 1024] !== 8'h06) begin bad++; $display("FAIL read_preload_ack: got %02h required 06", txbuf[bt % 1024]); end
    bt = tx_wr; bs = s_wr; ready_after = 5;
    send_byte(8'h72, acc); send_byte(8'h41, acc);
    wait_tx(bt + 2, ok);
    total++;
    if (!ok || {txbuf[bt % 1024], txbuf[(bt + 1) % 1024]} !== {mdl[8'h41][7:0], mdl[8'h41][15:8]}) begin
      bad++; $display("FAIL read_data: got %02h %02h required %02h %02h", txbuf[bt % 1024], txbuf[(bt + 1) % 1024], mdl[8'h41][7:0], mdl[8'h41][15:8]);
    end
    total++;
    if (s_wr - bs != 1 || slen[bs % 1024] != 5 || s_we[bs % 1024] != 1'b0) begin
      bad++; $display("FAIL read_strobe: pulses=%0d len=%0d we=%0b required 1/5/0", s_wr - bs, slen[bs % 1024], s_we[bs % 1024]);
    end
    ready_after = 1;
  endtask

  task automatic test_access_timeout();
    int bt, bs, acc;
    bit ok;
    bt = tx_wr; bs = s_wr; ready_en = 1'b0;
    send_byte(8'h72, acc); send_byte(8'h05, acc);
    wait_tx(bt + 1, ok);
    total++;
    if (!ok || txbuf[bt % 1024] !== 8'h15) begin bad++; $display("FAIL acc_to_nak: got %02h required 15", txbuf[bt % 1024]); end
    total++;
    if (s_wr - bs != 1 || slen[bs % 1024] != 15) begin
      bad++; $display("FAIL acc_to_len: pulses=%0d len=%0d required 1/15", s_wr - bs, slen[bs % 1024]);
    end
    repeat (2) @(negedge clk);
    total++;
    if (busy !== 1'b0) begin bad++; $display("FAIL acc_to_idle: busy=%0b required 0", busy); end
    ready_en = 1'b1;
    // Ready on the final allowed cycle must still succeed.
    bt = tx_wr; bs = s_wr; ready_after = 15;
    send_byte(8'h72, acc); send_byte(8'h06, acc);
    wait_tx(bt + 2, ok);
    total++;
    if (!ok || {txbuf[bt % 1024], txbuf[(bt + 1) % 1024]} !== {mdl[6][7:0], mdl[6][15:8]}) begin
      bad++; $display("FAIL acc_edge_data: got %02h %02h required %02h %02h", txbuf[bt % 1024], txbuf[(bt + 1) % 1024], mdl[6][7:0], mdl[6][15:8]);
    end
    total++;
    if (slen[bs % 1024] != 15) begin bad++; $display("FAIL acc_edge_len: len=%0d required 15", slen[bs % 1024]); end
    ready_after = 1;
  endtask

  task automatic test_bad_opcode();
    int bt, bs, acc;
    bit ok;
    bt = tx_wr; bs = s_wr;
    send_byte(8'h55, acc);
    wait_tx(bt + 1, ok);
    total++;
    if (!ok || txbuf[bt % 1024] !== 8'h15) begin bad++; $display("FAIL bad_op_55: got %02h required 15", txbuf[bt % 1024]); end
`ifndef DEBUG_BURST_READ_EN
    send_byte(8'h62, acc);
    wait_tx(bt + 2, ok);
    total++;
    if (!ok || txbuf[(bt + 1) % 1024] !== 8'h15) begin bad++; $display("FAIL bad_op_62: got %02h required 15", txbuf[(bt + 1) % 1024]); end
`endif
    total++;
    if (s_wr != bs) begin bad++; $display("FAIL bad_op_strobe: pulses=%0d required 0", s_wr - bs); end
  endtask

  task automatic test_frame_timeout();
    int bt, bs, acc, k;
    bit ok;
    bt = tx_wr; bs = s_wr;
    send_byte(8'h77, acc); send_byte(8'h10, acc);
    k = 0;
    @(negedge clk);
    while (cyc < acc + 14 && k < 100) begin @(negedge clk); k++; end
    total++;
    if (busy !== 1'b1) begin bad++; $display("FAIL frame_to_early: busy=%0b required 1", busy); end
    @(negedge clk);
    total++;
    if (busy !== 1'b0) begin bad++; $display("FAIL frame_to_idle: busy=%0b required 0", busy); end
    repeat (3) @(negedge clk);
    total++;
    if (tx_wr != bt || s_wr != bs) begin
      bad++; $display("FAIL frame_to_silent: tx=%0d strobes=%0d required 0/0", tx_wr - bt, s_wr - bs);
    end
    send_byte(8'h72, acc); send_byte(8'h10, acc);
    wait_tx(bt + 2, ok);
    total++;
    if (!ok || {txbuf[bt % 1024], txbuf[(bt + 1) % 1024]} !== {mdl[8'h10][7:0], mdl[8'h10][15:8]}) begin
      bad++; $display("FAIL frame_to_next: got %02h %02h required %02h %02h", txbuf[bt % 1024], txbuf[(bt + 1) % 1024], mdl[8'h10][7:0], mdl[8'h10][15:8]);
    end
  endtask

  task automatic test_backpressure();
    int bt, bs, acc, k;
    bit ok;
    bt = tx_wr; bs = s_wr;
    @(posedge clk); #1;
    bus.tx_ready = 1'b0;
    send_byte(8'h72, acc); send_byte(8'h41, acc);
    k = 0;
    while (!bus.tx_valid && k < 100) begin @(negedge clk); k++; end
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      total++;
      if ({bus.tx_valid, bus.tx_data, bus.rx_ready, bus.dbg_we, bus.dbg_rd} !== {1'b1, mdl[8'h41][7:0], 3'b000}) begin
        bad++; $display("FAIL stall_hold[%0d]: valid/data/rx_ready/we/rd=%0b/%02h/%0b/%0b/%0b required 1/%02h/0/0/0",
                        i, bus.tx_valid, bus.tx_data, bus.rx_ready, bus.dbg_we, bus.dbg_rd, mdl[8'h41][7:0]);
      end
    end
    @(posedge clk); #1;
    bus.tx_ready = 1'b1;
    wait_tx(bt + 2, ok);
    total++;
    if (!ok || {txbuf[bt % 1024], txbuf[(bt + 1) % 1024]} !== {mdl[8'h41][7:0], mdl[8'h41][15:8]}) begin
      bad++; $display("FAIL stall_data: got %02h %02h required %02h %02h", txbuf[bt % 1024], txbuf[(bt + 1) % 1024], mdl[8'h41][7:0], mdl[8'h41][15:8]);
    end
    total++;
    if (s_wr - bs != 1) begin bad++; $display("FAIL stall_strobes: pulses=%0d required 1", s_wr - bs); end
  endtask

`ifdef DEBUG_BURST_READ_EN
  task automatic test_burst();
    int bt, bs, acc;
    bit ok;
    logic [7:0] exp [6];
    for (int i = 0; i < 3; i++) begin
      exp[2 * i]     = mdl[8'h20][7:0];
      exp[2 * i + 1] = mdl[8'h20][15:8];
      mdl[8'h20]     = mdl[8'h20] + 16'd1;
    end
    bt = tx_wr; bs = s_wr; ready_after = 1;
    send_byte(8'h62, acc); send_byte(8'h20, acc); send_byte(8'h03, acc);
    wait_tx(bt + 6, ok);
    total++;
    if (!ok) begin bad++; $display("FAIL burst_count: tx=%0d required 6", tx_wr - bt); end
    for (int i = 0; i < 6; i++) begin
      total++;
      if (txbuf[(bt + i) % 1024] !== exp[i]) begin
        bad++; $display("FAIL burst_byte[%0d]: got %02h required %02h", i, txbuf[(bt + i) % 1024], exp[i]);
      end
    end
    total++;
    if (s_wr - bs != 3 || slen[bs % 1024] != 1 || slen[(bs + 1) % 1024] != 1 || slen[(bs + 2) % 1024] != 1) begin
      bad++; $display("FAIL burst_strobes: pulses=%0d lens=%0d,%0d,%0d required 3 of len 1",
                      s_wr - bs, slen[bs % 1024], slen[(bs + 1) % 1024], slen[(bs + 2) % 1024]);
    end
  endtask
`endif

  task automatic test_random();
    int bt, bs, acc, kind, n_exp, n_stb;
    bit ok;
    logic [7:0] op, a, lo, hi;
    logic [7:0] exp [2];
    for (int f = 0; f < 40; f++) begin
      kind = $urandom_range(0, 9);
      a  = 8'($urandom_range(0, 255));
      lo = 8'($urandom_range(0, 255));
      hi = 8'($urandom_range(0, 255));
      ready_after = $urandom_range(1, 6);
      bt = tx_wr; bs = s_wr;
      if (kind < 4) begin
        send_byte(8'h77, acc); send_byte(a, acc); send_byte(lo, acc); send_byte(hi, acc);
        mdl[a] = {hi, lo};
        exp[0] = 8'h06; n_exp = 1; n_stb = 1;
      end else if (kind < 9) begin
        if (kind == 8) a = 8'h20;
        send_byte(8'h72, acc); send_byte(a, acc);
        exp[0] = mdl[a][7:0]; exp[1] = mdl[a][15:8]; n_exp = 2; n_stb = 1;
        if (a == 8'h20) mdl[a] = mdl[a] + 16'd1;
      end else begin
        do op = 8'($urandom_range(0, 255)); while (op == 8'h77 || op == 8'h72 || op == 8'h62);
        send_byte(op, acc);
        exp[0] = 8'h15; n_exp = 1; n_stb = 0;
      end
      wait_tx(bt + n_exp, ok);
      total++;
      if (!ok || txbuf[bt % 1024] !== exp[0] || (n_exp == 2 && txbuf[(bt + 1) % 1024] !== exp[1])) begin
        bad++; $display("FAIL rand[%0d] kind=%0d a=%02h: got %02h %02h required %02h %02h (n=%0d)",
                        f, kind, a, txbuf[bt % 1024], txbuf[(bt + 1) % 1024], exp[0], exp[1], n_exp);
      end
      total++;
      if (s_wr - bs != n_stb) begin bad++; $display("FAIL rand_strobes[%0d]: pulses=%0d required %0d", f, s_wr - bs, n_stb); end
    end
    ready_after = 1;
  endtask

  task automatic test_reset_mid_access();
    int bt, acc, k;
    ready_en = 1'b0;
    send_byte(8'h72, acc); send_byte(8'h05, acc);
    k = 0;
    while (!bus.dbg_rd && k < 20) begin @(negedge clk); k++; end
    repeat (3) @(negedge clk);
    total++;
    if (bus.dbg_rd !== 1'b1) begin bad++; $display("FAIL midrst_pre: dbg_rd=%0b required 1", bus.dbg_rd); end
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    total++;
    if (out_vec() !== RST_VEC) begin bad++; $display("FAIL midrst_async: outputs=%h required %h", out_vec(), RST_VEC); end
    bt = tx_wr;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    ready_en = 1'b1;
    init_model();
    repeat (20) @(negedge clk);
    total++;
    if (tx_wr != bt || busy !== 1'b0 || bus.dbg_rd !== 1'b0) begin
      bad++; $display("FAIL midrst_after: tx=%0d busy=%0b rd=%0b required 0/0/0", tx_wr - bt, busy, bus.dbg_rd);
    end
  endtask

  initial begin
    bus.rx_data  = 8'h00;
    bus.rx_valid = 1'b0;
    bus.tx_ready = 1'b1;
    test_reset();
    test_write();
    test_read();
    test_access_timeout();
    test_bad_opcode();
    test_frame_timeout();
    test_backpressure();
`ifdef DEBUG_BURST_READ_EN
    test_burst();
`endif
    test_random();
    test_reset_mid_access();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/debug_cmd_engine.md
# debug_cmd_engine

Byte-stream command engine sitting directly upstream of the debug register file. It parses command frames from a byte source (UART RX or SPI slave), drives the `dbg_a`/`dbg_di`/`dbg_we`/`dbg_rd` register-access strobes and waits for `dbg_ready`. It then returns read data or ACK/NAK bytes on a byte sink. It also guards against stalled accesses and stalled frames with timeouts.

## Interface
Parameters:
- `TIMEOUT_BITS`, 8: width of the timeout counter; the limit is 2^TIMEOUT_BITS-1 cycles.

Ports:
- `clk`: input, 1 bit. System clock.
- `rst_n`: input, 1 bit. Reset, asynchronous and active-low.
- `rx_data`: input, 8 bits. Command byte.
- `rx_valid`: input, 1 bit. `rx_data` is valid.
- `rx_ready`: output, 1 bit. Engine accepts the byte; a transfer happens when `rx_valid & rx_ready`.
- `tx_data`: output, 8 bits. Response byte.
- `tx_valid`: output, 1 bit. `tx_data` is valid.
- `tx_ready`: input, 1 bit. Sink accepts the byte.
- `dbg_a`: output, 8 bits. Register address.
- `dbg_di`: output, 16 bits. Write data.
- `dbg_we`: output, 1 bit. Write strobe.
- `dbg_rd`: output, 1 bit. Read strobe.
- `dbg_do`: input, 16 bits. Read data; valid while `dbg_rd` is high.
- `dbg_ready`: input, 1 bit. Access complete; may be combinational from the strobes.
- `busy`: output, 1 bit. High in any state other than IDLE.

## Operation
- Frame formats:
  - Write: `0x77`, addr, dlo, dhi.
  - Read: `0x72`, addr.
  - Burst read: `0x62`, addr, count (when compiled in).
- Responses:
  - Write success: ACK `0x06`.
  - Read success: lo byte, then hi byte.
  - Failure: NAK `0x15`.
- States: IDLE, ADDR, DLO, DHI, CNT, ACCESS, TX_LO, TX_HI, TX_ACK, TX_NAK.
- IDLE:
  - Accept a byte.
  - `0x77` or `0x72` goes to ADDR and records the opcode.
  - `0x62` (if enabled) goes to ADDR.
  - Any other byte goes to TX_NAK.
- Frame collection:
  - ADDR latches `dbg_a`, then moves to DLO for a write, CNT for a burst read, or ACCESS for a read.
  - DLO latches `dbg_di[7:0]`; DHI latches `dbg_di[15:8]`, then moves to ACCESS.
  - CNT latches an 8-bit burst count; a count of 0 is treated as 256. It then moves to ACCESS.
- ACCESS:
  - `dbg_we` (write) or `dbg_rd` (read) is held high until a cycle in which `dbg_ready` is high.
  - In that cycle, read data `dbg_do` is captured into a 16-bit holding register.
  - The strobe is low from the following cycle, so the downstream auto-increment at address 0x20 fires exactly once per access.
  - Then go to TX_ACK (write) or TX_LO (read).
- TX states:
  - `tx_valid` is high with the byte; the state advances on `tx_ready`.
  - TX_LO → TX_HI.
  - TX_HI → IDLE, or back to ACCESS if the burst count remaining is non-zero after decrement.
  - TX_ACK and TX_NAK → IDLE.
- Access timeout: if `dbg_ready` stays low for 2^TIMEOUT_BITS-1 cycles in ACCESS, drop the strobe, abandon the rest of any burst and go to TX_NAK.
- Inter-byte timeout: in ADDR, DLO, DHI or CNT, if no byte arrives for 2^TIMEOUT_BITS-1 cycles, return to IDLE silently with no response.
- `rx_ready` is high only in IDLE, ADDR, DLO, DHI and CNT; bytes arriving during an access or response are back-pressured, never dropped.
- `dbg_a` and `dbg_di` hold their values outside ACCESS; they change only on frame capture.

## Timing
- Reset values:
  - State IDLE.
  - `rx_ready`=1.
  - `tx_valid`=0, `tx_data`=0.
  - `dbg_a`=0, `dbg_di`=0.
  - `dbg_we`=0, `dbg_rd`=0.
  - `busy`=0.
  - Timeout counter and burst counter 0.
- Reset asserted mid-access drops the strobes asynchronously; no response is sent.
- All outputs are registered except `rx_ready` and `busy`, which decode the state register.
- Strobe latency: the strobe rises the cycle after the final frame byte is accepted.
- With a combinational `dbg_ready`, an access lasts exactly 1 cycle.
- The first response byte is valid the cycle after the access completes.
- The timeout counter clears on every state change and on every accepted byte.
- If `dbg_ready` arrives in the same cycle as the timeout limit, `dbg_ready` wins and the access succeeds.

## Configuration
- `DEBUG_BURST_READ_EN` defined: the `0x62` opcode, the CNT state and the burst counter are compiled in.
- Burst behaviour: repeated reads of the same `dbg_a`, each returning lo then hi; no gap beyond the per-byte handshake.
- `DEBUG_BURST_READ_EN` undefined: `0x62` is an unknown opcode and gets NAK; the CNT state and counter are absent.

## Test plan
- Write frame `77 1A 34 12` with the responder giving `dbg_ready` in the same cycle → `dbg_a`=0x1A, `dbg_di`=0x1234, `dbg_we` high for 1 cycle, then TX `06`.
- Read frame `72 41` with `dbg_do`=0xBEEF and `dbg_ready` after 5 cycles → `dbg_rd` high for 5 cycles, then TX `EF BE`.
- Read of address 0x05 where `dbg_ready` never rises (`TIMEOUT_BITS`=4) → `dbg_rd` drops after 15 cycles, then TX `15`, then back to IDLE.
- Opcode `0x55` → TX `15`; a frame `77 10` followed by 15 idle cycles (`TIMEOUT_BITS`=4) → silent return to IDLE; a following `72 10` is processed normally.
- With `DEBUG_BURST_READ_EN`, frame `62 20 03` with `dbg_do` incrementing per access → 3 single-cycle `dbg_rd` pulses and 6 TX bytes in order.
- Hold `tx_ready` low for 20 cycles during TX_LO → `tx_data` stays stable, `rx_ready`=0, no strobe re-issued; assert `rst_n` low mid-ACCESS → all outputs return to reset values immediately.
